jtframe_ram_arb: RTL

- Two-requester arbiter that shares one single-port synchronous RAM (registered read, 1-cycle latency, write gated by cen) between a CPU-side port A and a video/DMA-side port B.
- Sequences every access as a 3-state transaction and returns read data with a one-cycle ok pulse per access.
- Sits between the two requesters and the RAM instance inside a core's memory subsystem.

---
 rtl/jtframe_ram_arb_sel.sv | 14 +
 rtl/jtframe_ram_arb.sv | 122 ++++++++++++
 2 files changed

// File: rtl/jtframe_ram_arb_sel.sv
// rtl/jtframe_ram_arb_sel.sv - combinational grant selection for jtframe_ram_arb
module jtframe_ram_arb_sel #(
    parameter int PRIO_A = 0
) (
    input  logic a_req_i,
    input  logic b_req_i,
    input  logic last_b_i,
    output logic grant_b_o
);
    localparam logic ROUND_ROBIN = (PRIO_A == 0);

    // B wins alone, or on a conflict when round-robin is on and A went last
    assign grant_b_o = b_req_i & (~a_req_i | (ROUND_ROBIN & ~last_b_i));
endmodule

// File: rtl/jtframe_ram_arb.sv
// rtl/jtframe_ram_arb.sv - two-port arbiter in front of one single-port synchronous RAM
module jtframe_ram_arb #(
    parameter int AW     = 10,
    parameter int DW     = 8,
    parameter int PRIO_A = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic [DW-1:0] a_dout,
    output logic          a_ok,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic [DW-1:0] b_dout,
    output logic          b_ok,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_we,
    output logic          ram_cen,
    input  logic [DW-1:0] ram_q
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_b_q, last_b_d;
    logic          grant_b_q, grant_b_d;
    logic          sel_b;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          we_q, we_d;
    logic          a_ok_q, a_ok_d, b_ok_q, b_ok_d;
    logic [DW-1:0] a_dout_q, a_dout_d, b_dout_q, b_dout_d;

    jtframe_ram_arb_sel #(.PRIO_A(PRIO_A)) u_sel (
        .a_req_i   (a_req),
        .b_req_i   (b_req),
        .last_b_i  (last_b_q),
        .grant_b_o (sel_b)
    );

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        grant_b_d = grant_b_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = we_q;
        a_ok_d    = 1'b0;
        b_ok_d    = 1'b0;
        // ok lasts one clk even if cen stalls DONE; dout keeps what was shown
        a_dout_d  = a_ok_q ? ram_q : a_dout_q;
        b_dout_d  = b_ok_q ? ram_q : b_dout_q;
        case (state_q)
            ST_IDLE: begin
                if (cen && (a_req || b_req)) begin
                    grant_b_d = sel_b;
                    last_b_d  = sel_b;
                    addr_d    = sel_b ? b_addr : a_addr;
                    data_d    = sel_b ? b_din  : a_din;
                    we_d      = sel_b ? b_we   : a_we;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cen) begin
                    we_d    = 1'b0;
                    a_ok_d  = ~grant_b_q;
                    b_ok_d  = grant_b_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cen) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_b_q  <= 1'b1;
            grant_b_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            a_ok_q    <= 1'b0;
            b_ok_q    <= 1'b0;
            a_dout_q  <= '0;
            b_dout_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            grant_b_q <= grant_b_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            a_ok_q    <= a_ok_d;
            b_ok_q    <= b_ok_d;
            a_dout_q  <= a_dout_d;
            b_dout_q  <= b_dout_d;
        end
    end

    // RAM q only becomes valid in DONE, so the ok cycle forwards it directly
    assign a_dout   = a_ok_q ? ram_q : a_dout_q;
    assign b_dout   = b_ok_q ? ram_q : b_dout_q;
    assign a_ok     = a_ok_q;
    assign b_ok     = b_ok_q;
    assign ram_addr = addr_q;
    assign ram_data = data_q;
    assign ram_we   = we_q;
    assign ram_cen  = (state_q == ST_ACCESS) & cen;
endmodule
